// File: rtl/register_file_sb_if.sv
// Register file bus between the pipeline and register_file_sb.
// Purpose: groups the decode-side read/reserve signals and the
// writeback-side write/release signals into one bundle.
// Signals:
//   w_address_s1/s2   read port addresses (decode)
//   w_data_s1val/s2val read port data (combinational, with bypass)
//   w_busy_s1/s2      pending-writer flags for the read addresses
//   w_en/w_address_d/w_data_dval  write port (writeback), also releases busy
//   w_rsv_en/w_rsv_address        reserve port (decode marks destination busy)
//   w_outstanding     registered count of busy registers
//   w_rsv_conflict    registered pulse: reserve hit a still-busy register
// Modports: master = pipeline side, slave = register file side.
interface register_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] w_address_s1;
  logic [ADDR_W-1:0] w_address_s2;
  logic [DATA_W-1:0] w_data_s1val;
  logic [DATA_W-1:0] w_data_s2val;
  logic              w_busy_s1;
  logic              w_busy_s2;
  logic              w_en;
  logic [ADDR_W-1:0] w_address_d;
  logic [DATA_W-1:0] w_data_dval;
  logic              w_rsv_en;
  logic [ADDR_W-1:0] w_rsv_address;
  logic [ADDR_W:0]   w_outstanding;
  logic              w_rsv_conflict;

  modport master (
    output w_address_s1, w_address_s2, w_en, w_address_d, w_data_dval,
           w_rsv_en, w_rsv_address,
    input  w_data_s1val, w_data_s2val, w_busy_s1, w_busy_s2,
           w_outstanding, w_rsv_conflict
  );

  modport slave (
    input  w_address_s1, w_address_s2, w_en, w_address_d, w_data_dval,
           w_rsv_en, w_rsv_address,
    output w_data_s1val, w_data_s2val, w_busy_s1, w_busy_s2,
           w_outstanding, w_rsv_conflict
  );
endinterface

// File: rtl/register_file_sb.sv
// register_file_sb: two-read / one-write register file with write-to-read
// bypass, optional hardwired zero register and a per-register busy
// scoreboard so decode can detect RAW hazards on pending writers.
// Ports:
//   clock    sole clock, all state updates on posedge
//   reset_n  asynchronous active-low reset
//   bus      register_file_sb_if.slave (read, write, reserve, status)
module register_file_sb #(
  parameter int          DATA_W   = 32,
  parameter int          ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter int          SP_INDEX = 29,
  parameter logic [31:0] SP_INIT  = 32'h00008000
) (
  input logic              clock,
  input logic              reset_n,
  register_file_sb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   outstanding_q, outstanding_d;
  logic              conflict_q, conflict_d;

  // Register 0 is treated as constant zero only when ZERO_REG is enabled.
  function automatic logic isZero(input logic [ADDR_W-1:0] addr);
    return ZERO_REG && (addr == '0);
  endfunction

  // A write in the current cycle is visible to readers immediately, so the
  // read path returns the write data and reports no pending writer.
  function automatic logic writeHits(input logic [ADDR_W-1:0] addr);
    return bus.w_en && (bus.w_address_d == addr);
  endfunction

  function automatic logic [DATA_W-1:0] readData(input logic [ADDR_W-1:0] addr);
    if (isZero(addr))         return '0;
    else if (writeHits(addr)) return bus.w_data_dval;
    else                      return regs_q[addr];
  endfunction

  function automatic logic readBusy(input logic [ADDR_W-1:0] addr);
    return !isZero(addr) && busy_q[addr] && !writeHits(addr);
  endfunction

  assign bus.w_data_s1val   = readData(bus.w_address_s1);
  assign bus.w_data_s2val   = readData(bus.w_address_s2);
  assign bus.w_busy_s1      = readBusy(bus.w_address_s1);
  assign bus.w_busy_s2      = readBusy(bus.w_address_s2);
  assign bus.w_outstanding  = outstanding_q;
  assign bus.w_rsv_conflict = conflict_q;

  // Scoreboard next state: release first, then reserve, so a same-cycle
  // write and reserve of one register leaves it busy for the new writer.
  // The outstanding count is the popcount of the next busy vector so it
  // tracks the busy bits with the same one-cycle registration.
  always_comb begin
    busy_d        = busy_q;
    outstanding_d = '0;
    conflict_d    = 1'b0;
    if (bus.w_en) begin
      busy_d[bus.w_address_d] = 1'b0;
    end
    if (bus.w_rsv_en && !isZero(bus.w_rsv_address)) begin
      busy_d[bus.w_rsv_address] = 1'b1;
      conflict_d = busy_q[bus.w_rsv_address] && !writeHits(bus.w_rsv_address);
    end
    for (int k = 0; k < DEPTH; k++) begin
      outstanding_d = outstanding_d + (ADDR_W+1)'(busy_d[k]);
    end
  end

  // Register array: reset loads each register with its own index (handy
  // for bring-up) and the stack pointer with its initial value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        regs_q[k] <= (k == SP_INDEX) ? DATA_W'(SP_INIT) : DATA_W'(k);
      end
    end else if (bus.w_en && !isZero(bus.w_address_d)) begin
      regs_q[bus.w_address_d] <= bus.w_data_dval;
    end
  end

  // Scoreboard state; reset drops every pending reservation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q        <= '0;
      outstanding_q <= '0;
      conflict_q    <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
      conflict_q    <= conflict_d;
    end
  end
endmodule

// File: tb/tb_register_file_sb.sv
// Directed testbench for register_file_sb. Expected values are queued on
// a scoreboard as stimulus is applied and popped when outputs are sampled.
module tb_register_file_sb;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  string       tagQ[$];
  logic [31:0] expQ[$];

  register_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  register_file_sb #(
    .DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .SP_INDEX(29), .SP_INIT(32'h00008000)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );

  // 10 ns clock, posedges at 5, 15, 25, ...
  always #5 clock = ~clock;

  // Drive every pipeline-side input at once.
  task automatic applyStimulus(input logic [4:0] s1, input logic [4:0] s2,
                               input logic wen, input logic [4:0] wd,
                               input logic [31:0] wdata, input logic rsven,
                               input logic [4:0] rsva);
    bus.w_address_s1  = s1;
    bus.w_address_s2  = s2;
    bus.w_en          = wen;
    bus.w_address_d   = wd;
    bus.w_data_dval   = wdata;
    bus.w_rsv_en      = rsven;
    bus.w_rsv_address = rsva;
  endtask

  // Push an expected value onto the scoreboard.
  task automatic expectVal(input string tag, input logic [31:0] value);
    tagQ.push_back(tag);
    expQ.push_back(value);
  endtask

  // Pop the oldest expected value and compare it with the observed one.
  task automatic checkOutput(input logic [31:0] observed);
    string       tag;
    logic [31:0] expected;
    checks++;
    if (expQ.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty observed=%h expected=none", observed);
    end else begin
      tag      = tagQ.pop_front();
      expected = expQ.pop_front();
      assert (observed === expected) else begin
        failures++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
    end
  endtask

  task automatic nextCycle();
    @(negedge clock);
  endtask

  initial begin
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    nextCycle();
    nextCycle();
    reset_n = 1'b1;

    // Reset values and register index initialisation
    applyStimulus(5'd5, 5'd29, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expectVal("reset_s1", 32'h5);
    expectVal("reset_s2_sp", 32'h00008000);
    expectVal("reset_busy_s1", 32'h0);
    expectVal("reset_busy_s2", 32'h0);
    expectVal("reset_outstanding", 32'h0);
    expectVal("reset_conflict", 32'h0);
    #1;
    checkOutput(bus.w_data_s1val);
    checkOutput(bus.w_data_s2val);
    checkOutput(32'(bus.w_busy_s1));
    checkOutput(32'(bus.w_busy_s2));
    checkOutput(32'(bus.w_outstanding));
    checkOutput(32'(bus.w_rsv_conflict));

    // Write with same-cycle bypass, then value held after the edge
    nextCycle();
    applyStimulus(5'd7, 5'd5, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0);
    expectVal("bypass_s1", 32'hDEADBEEF);
    expectVal("bypass_other_port", 32'h5);
    #1;
    checkOutput(bus.w_data_s1val);
    checkOutput(bus.w_data_s2val);
    nextCycle();
    applyStimulus(5'd7, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expectVal("stored_s1", 32'hDEADBEEF);
    expectVal("stored_s2", 32'hDEADBEEF);
    #1;
    checkOutput(bus.w_data_s1val);
    checkOutput(bus.w_data_s2val);

    // Hardwired zero ignores writes and reserves
    nextCycle();
    applyStimulus(5'd0, 5'd0, 1'b1, 5'd0, 32'h1234, 1'b1, 5'd0);
    expectVal("zero_bypass_s1", 32'h0);
    expectVal("zero_busy_s1", 32'h0);
    #1;
    checkOutput(bus.w_data_s1val);
    checkOutput(32'(bus.w_busy_s1));
    nextCycle();
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expectVal("zero_after_s1", 32'h0);
    expectVal("zero_after_busy", 32'h0);
    expectVal("zero_after_outstanding", 32'h0);
    #1;
    checkOutput(bus.w_data_s1val);
    checkOutput(32'(bus.w_busy_s1));
    checkOutput(32'(bus.w_outstanding));

    // Reserve 9, hold, then release by writeback
    nextCycle();
    applyStimulus(5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    expectVal("rsv9_busy_before_edge", 32'h0);
    #1;
    checkOutput(32'(bus.w_busy_s1));
    nextCycle();
    applyStimulus(5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      expectVal("rsv9_busy_hold", 32'h1);
      expectVal("rsv9_outstanding_hold", 32'h1);
      #1;
      checkOutput(32'(bus.w_busy_s1));
      checkOutput(32'(bus.w_outstanding));
      nextCycle();
    end
    applyStimulus(5'd9, 5'd0, 1'b1, 5'd9, 32'hA5, 1'b0, 5'd0);
    expectVal("wb9_busy_bypass", 32'h0);
    expectVal("wb9_data_bypass", 32'hA5);
    expectVal("wb9_outstanding_before_edge", 32'h1);
    #1;
    checkOutput(32'(bus.w_busy_s1));
    checkOutput(bus.w_data_s1val);
    checkOutput(32'(bus.w_outstanding));
    nextCycle();
    applyStimulus(5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expectVal("wb9_outstanding_after", 32'h0);
    expectVal("wb9_busy_after", 32'h0);
    expectVal("wb9_data_after", 32'hA5);
    #1;
    checkOutput(32'(bus.w_outstanding));
    checkOutput(32'(bus.w_busy_s1));
    checkOutput(bus.w_data_s1val);

    // Double reserve of 4 raises a one-cycle conflict pulse
    nextCycle();
    applyStimulus(5'd0, 5'd4, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    nextCycle();
    applyStimulus(5'd0, 5'd4, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    expectVal("rsv4_first_no_conflict", 32'h0);
    expectVal("rsv4_first_outstanding", 32'h1);
    #1;
    checkOutput(32'(bus.w_rsv_conflict));
    checkOutput(32'(bus.w_outstanding));
    nextCycle();
    applyStimulus(5'd0, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expectVal("rsv4_conflict_pulse", 32'h1);
    expectVal("rsv4_outstanding", 32'h1);
    #1;
    checkOutput(32'(bus.w_rsv_conflict));
    checkOutput(32'(bus.w_outstanding));
    nextCycle();
    expectVal("rsv4_conflict_drop", 32'h0);
    #1;
    checkOutput(32'(bus.w_rsv_conflict));

    // Same-cycle write and reserve of 4: reserve wins, no conflict
    nextCycle();
    applyStimulus(5'd0, 5'd4, 1'b1, 5'd4, 32'h44, 1'b1, 5'd4);
    expectVal("wr_rsv4_busy_bypass", 32'h0);
    #1;
    checkOutput(32'(bus.w_busy_s2));
    nextCycle();
    applyStimulus(5'd0, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expectVal("wr_rsv4_conflict", 32'h0);
    expectVal("wr_rsv4_busy", 32'h1);
    expectVal("wr_rsv4_outstanding", 32'h1);
    expectVal("wr_rsv4_data", 32'h44);
    #1;
    checkOutput(32'(bus.w_rsv_conflict));
    checkOutput(32'(bus.w_busy_s2));
    checkOutput(32'(bus.w_outstanding));
    checkOutput(bus.w_data_s2val);

    // Reserve 3, 8, 12 then asynchronous reset between edges
    nextCycle();
    applyStimulus(5'd3, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3);
    nextCycle();
    applyStimulus(5'd3, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8);
    nextCycle();
    applyStimulus(5'd3, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12);
    nextCycle();
    applyStimulus(5'd3, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    expectVal("multi_outstanding", 32'h4);
    expectVal("multi_busy_s1", 32'h1);
    #1;
    checkOutput(32'(bus.w_outstanding));
    checkOutput(32'(bus.w_busy_s1));
    #2;
    reset_n = 1'b0;
    expectVal("async_rst_busy_s1", 32'h0);
    expectVal("async_rst_outstanding", 32'h0);
    expectVal("async_rst_s1", 32'h3);
    expectVal("async_rst_s2", 32'h7);
    expectVal("async_rst_conflict", 32'h0);
    #1;
    checkOutput(32'(bus.w_busy_s1));
    checkOutput(32'(bus.w_outstanding));
    checkOutput(bus.w_data_s1val);
    checkOutput(bus.w_data_s2val);
    checkOutput(32'(bus.w_rsv_conflict));
    nextCycle();
    reset_n = 1'b1;
    nextCycle();
    expectVal("post_rst_busy_s1", 32'h0);
    expectVal("post_rst_outstanding", 32'h0);
    #1;
    checkOutput(32'(bus.w_busy_s1));
    checkOutput(32'(bus.w_outstanding));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
